// File: rtl/edabk_uart_pkg.sv
// Shared UART constants: parity mode selectors and frame length helper.
package edabk_uart_pkg;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

  // start + payload + optional parity + stop
  function automatic int frame_len(input int data_width, input int parity_en);
    return data_width + 2 + parity_en;
  endfunction

endpackage

// File: rtl/edabk_baud_tick_counter.sv
// Free-running bit timer: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module edabk_baud_tick_counter #(
  parameter int CLK_DIV = 16
) (
  input  logic bclk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == CNT_MAX) ? '0 : count_reg + CNT_W'(1);
    end
  end

  assign tick = enable && (count_reg == CNT_MAX);

endmodule

// File: rtl/edabk_uart_transceiver_define.svh
// Build-time defaults for the UART transceiver blocks.
`ifndef EDABK_UART_TRANSCEIVER_DEFINE_SVH
`define EDABK_UART_TRANSCEIVER_DEFINE_SVH

`define CFG_CLK_DIV    16
`define CFG_DATA_WIDTH 8

`endif

// File: rtl/edabk_transmitter_datapath.sv
// UART transmit datapath: frame shift register, bits-left counter and bit timer.
`include "edabk_uart_transceiver_define.svh"

module edabk_transmitter_datapath
  import edabk_uart_pkg::*;
#(
  parameter int CLK_DIV    = `CFG_CLK_DIV,
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  bclk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  output logic                  tx,
  output logic                  done,
  output logic                  busy
);

  localparam int FRAME_LEN = frame_len(DATA_WIDTH, PARITY_EN);
  localparam int BL_W      = $clog2(FRAME_LEN + 1);

  logic [FRAME_LEN-1:0] frame_reg;
  logic [FRAME_LEN-1:0] load_frame;
  logic [BL_W-1:0]      bits_left_reg;
  logic                 busy_reg;
  logic                 last_shift;
  logic                 timer_restart;
  logic                 tick;

  generate
    if (PARITY_EN != 0) begin : g_parity
      logic par_bit;
      assign par_bit    = (^data_in) ^ (PARITY_ODD == PAR_MODE_ODD);
      assign load_frame = {1'b1, par_bit, data_in, 1'b0};
    end else begin : g_no_parity
      assign load_frame = {1'b1, data_in, 1'b0};
    end
  endgenerate

  assign last_shift    = shift && busy_reg && (bits_left_reg == BL_W'(1));
  // Every path that leaves or re-enters a frame realigns the timer to bit start.
  assign timer_restart = load || clear || last_shift;

  edabk_baud_tick_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick_counter (
    .bclk    (bclk),
    .reset_n (reset_n),
    .enable  (busy_reg),
    .restart (timer_restart),
    .tick    (tick)
  );

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_reg     <= '1;
      bits_left_reg <= '0;
      busy_reg      <= 1'b0;
    end else if (load) begin
      frame_reg     <= load_frame;
      bits_left_reg <= BL_W'(FRAME_LEN);
      busy_reg      <= 1'b1;
    end else if (clear) begin
      frame_reg     <= '1;
      bits_left_reg <= '0;
      busy_reg      <= 1'b0;
    end else if (shift && busy_reg) begin
      if (last_shift) begin
        frame_reg     <= '1;
        bits_left_reg <= '0;
        busy_reg      <= 1'b0;
      end else begin
        frame_reg     <= {1'b1, frame_reg[FRAME_LEN-1:1]};
        bits_left_reg <= bits_left_reg - BL_W'(1);
      end
    end
  end

  assign tx   = frame_reg[0];
  assign done = tick;
  assign busy = busy_reg;

endmodule

// File: tb/tb_edabk_transmitter_datapath.sv
// Scoreboard bench: stimulus queues expected tx bits, monitors pop them on each done pulse.
module tb_edabk_transmitter_datapath;

  logic       bclk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in, data_par;
  logic       load, clear, shift_force, load_par;
  logic       tx, done, busy, shift;
  logic       tx_e, done_e, busy_e;
  logic       tx_o, done_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic q_main[$];
  logic q_even[$];
  logic q_odd[$];

  int   hold_cnt    = 0;
  logic expect_idle = 1'b0;
  logic exp_m, exp_e, exp_o;

  always #5 bclk = ~bclk;

  assign shift = shift_force | done;

  edabk_transmitter_datapath #(
    .CLK_DIV(16), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut (
    .bclk(bclk), .reset_n(reset_n), .data_in(data_in), .load(load),
    .shift(shift), .clear(clear), .tx(tx), .done(done), .busy(busy)
  );

  edabk_transmitter_datapath #(
    .CLK_DIV(16), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_par_even (
    .bclk(bclk), .reset_n(reset_n), .data_in(data_par), .load(load_par),
    .shift(done_e), .clear(1'b0), .tx(tx_e), .done(done_e), .busy(busy_e)
  );

  edabk_transmitter_datapath #(
    .CLK_DIV(16), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)
  ) u_par_odd (
    .bclk(bclk), .reset_n(reset_n), .data_in(data_par), .load(load_par),
    .shift(done_o), .clear(1'b0), .tx(tx_o), .done(done_o), .busy(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // bits[0] is the first bit on the line
  task automatic push_main(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) q_main.push_back(bits[i]);
  endtask

  task automatic pulse_load(input logic [7:0] d);
    @(posedge bclk); #1;
    data_in = d;
    load    = 1'b1;
    @(posedge bclk); #1;
    load    = 1'b0;
  endtask

  task automatic wait_main_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge bclk);
      if (q_main.size() == 0 && !busy) return;
    end
    flag({name, "_timeout"});
  endtask

  task automatic wait_main_size(input int n, input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge bclk);
      if (q_main.size() == n) return;
    end
    flag({name, "_timeout"});
  endtask

  // Main monitor: bit value and bit duration at every done pulse.
  initial begin
    forever begin
      @(negedge bclk);
      if (expect_idle) begin
        check("frame_end_busy", {31'd0, busy}, 32'd0);
        check("frame_end_tx", {31'd0, tx}, 32'd1);
        expect_idle = 1'b0;
      end
      if (!reset_n || load) hold_cnt = 0;
      else if (busy) hold_cnt++;
      if (done) begin
        check("bit_hold_cycles", hold_cnt, 32'd16);
        hold_cnt = 0;
        if (q_main.size() == 0) begin
          flag("unexpected_done_main");
        end else begin
          exp_m = q_main.pop_front();
          check("tx_bit_main", {31'd0, tx}, {31'd0, exp_m});
          if (q_main.size() == 0) expect_idle = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge bclk);
      if (done_e) begin
        if (q_even.size() == 0) flag("unexpected_done_even");
        else begin
          exp_e = q_even.pop_front();
          check("tx_bit_even", {31'd0, tx_e}, {31'd0, exp_e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge bclk);
      if (done_o) begin
        if (q_odd.size() == 0) flag("unexpected_done_odd");
        else begin
          exp_o = q_odd.pop_front();
          check("tx_bit_odd", {31'd0, tx_o}, {31'd0, exp_o});
        end
      end
    end
  end

  initial begin
    logic [15:0] par_even_bits;
    logic [15:0] par_odd_bits;
    reset_n = 1'b0; data_in = '0; data_par = '0;
    load = 1'b0; clear = 1'b0; shift_force = 1'b0; load_par = 1'b0;

    repeat (3) @(posedge bclk);
    @(negedge bclk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge bclk); #1;
    reset_n = 1'b1;

    // Shift while idle is ignored
    @(posedge bclk); #1;
    shift_force = 1'b1;
    @(posedge bclk); #1;
    shift_force = 1'b0;
    @(negedge bclk);
    check("idle_shift_tx", {31'd0, tx}, 32'd1);
    check("idle_shift_busy", {31'd0, busy}, 32'd0);

    // 0xA5: 0,1,0,1,0,0,1,0,1,1
    push_main(16'b0000_0011_0100_1010, 10);
    pulse_load(8'hA5);
    @(negedge bclk);
    check("a5_start_tx", {31'd0, tx}, 32'd0);
    check("a5_start_busy", {31'd0, busy}, 32'd1);
    wait_main_idle("a5_frame");
    repeat (4) @(posedge bclk);

    // 0x5A, cleared after three bits
    push_main(16'b0000_0010_1011_0100, 10);
    pulse_load(8'h5A);
    wait_main_size(7, "clear_wait");
    repeat (5) @(posedge bclk);
    #1;
    clear = 1'b1;
    q_main.delete();
    @(posedge bclk); #1;
    clear = 1'b0;
    @(negedge bclk);
    check("clear_tx", {31'd0, tx}, 32'd1);
    check("clear_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge bclk);

    // Restart with 0x3C while sending bit 5 of 0xA5
    push_main(16'b0000_0011_0100_1010, 10);
    pulse_load(8'hA5);
    wait_main_size(5, "restart_wait");
    repeat (7) @(posedge bclk);
    #1;
    q_main.delete();
    push_main(16'b0000_0010_0111_1000, 10);
    data_in = 8'h3C;
    load    = 1'b1;
    @(posedge bclk); #1;
    load    = 1'b0;
    @(negedge bclk);
    check("restart_tx", {31'd0, tx}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    wait_main_idle("restart_frame");
    repeat (4) @(posedge bclk);

    // load + shift + clear together: load wins
    push_main(16'b0000_0011_0100_1010, 10);
    @(posedge bclk); #1;
    data_in = 8'hA5; load = 1'b1; clear = 1'b1; shift_force = 1'b1;
    @(posedge bclk); #1;
    load = 1'b0; clear = 1'b0; shift_force = 1'b0;
    @(negedge bclk);
    check("prio_tx", {31'd0, tx}, 32'd0);
    check("prio_busy", {31'd0, busy}, 32'd1);
    wait_main_idle("prio_frame");
    repeat (4) @(posedge bclk);

    // Parity 0x07: 0,1,1,1,0,0,0,0,0,P,1 with P=1 even, P=0 odd
    par_even_bits = 16'b0000_0110_0000_1110;
    par_odd_bits  = 16'b0000_0100_0000_1110;
    for (int i = 0; i < 11; i++) begin
      q_even.push_back(par_even_bits[i]);
      q_odd.push_back(par_odd_bits[i]);
    end
    @(posedge bclk); #1;
    data_par = 8'h07; load_par = 1'b1;
    @(posedge bclk); #1;
    load_par = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge bclk);
      if (q_even.size() == 0 && q_odd.size() == 0 && !busy_e && !busy_o) break;
    end
    check("par_even_left", q_even.size(), 32'd0);
    check("par_odd_left", q_odd.size(), 32'd0);
    check("par_even_idle", {31'd0, busy_e}, 32'd0);
    check("par_odd_idle", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-frame
    push_main(16'b0000_0011_0100_1010, 10);
    pulse_load(8'hA5);
    repeat (40) @(posedge bclk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    q_main.delete();
    repeat (2) @(posedge bclk);
    #1;
    reset_n = 1'b1;
    repeat (50) @(negedge bclk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edabk_transmitter_datapath.md
EDABK_TRANSMITTER_DATAPATH -- requirements
Module: edabk_transmitter_datapath

Interface
REQ-001 SHALL have parameter CLK_DIV, default `CFG_CLK_DIV, bclk cycles per serial bit (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default `CFG_DATA_WIDTH, payload bits per frame.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = insert parity bit before stop bit.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, as listed below.
REQ-006 SHALL have port bclk  input  1  baud clock; all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous reset, active low.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  payload, sampled only on load.
REQ-009 SHALL have port load  input  1  capture frame from data_in.
REQ-010 SHALL have port shift  input  1  advance frame register by one bit.
REQ-011 SHALL have port clear  input  1  abort/idle the datapath.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port done  output  1  one-cycle pulse: current bit period complete.
REQ-014 SHALL have port busy  output  1  frame in progress.

Function
REQ-015 SHALL define FRAME_LEN = DATA_WIDTH + 2 + PARITY_EN; frame = start(0), data LSB first, [parity], stop(1).
REQ-016 SHALL apply command priority load > clear > shift when asserted together in one cycle.
REQ-017 On load: frame register <= {1, [parity], data_in, 0}, bit timer <= 0, bits_left <= FRAME_LEN, busy <= 1, next cycle; load while busy restarts the frame.
REQ-018 Parity bit SHALL equal XOR of data_in, inverted when PARITY_ODD=1.
REQ-019 tx SHALL equal frame register bit 0 (flop output, no combinational path from inputs).
REQ-020 Bit timer SHALL count 0..CLK_DIV-1 only while busy, wrapping to 0; done = 1 exactly in cycles where timer == CLK_DIV-1 and busy.
REQ-021 On shift while busy: register shifts right, MSB filled with 1, bits_left decrements; timer keeps free-running (no reset), preserving bit alignment.
REQ-022 Shift coincident with done SHALL be the normal case (controller asserts shift combinationally from done).
REQ-023 When the shift that takes bits_left from 1 to 0 occurs, busy <= 0, timer <= 0, register <= all ones; tx = 1 thereafter.
REQ-024 Shift while not busy SHALL be ignored (no state change).
REQ-025 On clear (load low): register <= all ones, timer <= 0, bits_left <= 0, busy <= 0, done suppressed from next cycle.
REQ-026 Each bit SHALL be held on tx for exactly CLK_DIV cycles when shift is driven only by done.

Reset
REQ-027 Under reset_n=0: tx=1, done=0, busy=0, register all ones, timer=0, bits_left=0, immediately and asynchronously.
REQ-028 Reset mid-frame SHALL abandon the frame; after release the block idles until load.

Structure
REQ-029 Shared package edabk_uart_pkg SHALL hold parity mode constants and FRAME_LEN function; CFG_* defaults stay in edabk_uart_transceiver_define.svh.
REQ-030 Bit timer SHALL be sub-module edabk_baud_tick_counter (inputs bclk, reset_n, enable, restart; output tick).
REQ-031 Widths: timer $clog2(CLK_DIV), bits_left $clog2(FRAME_LEN+1); no truncation warnings.

Verification (DATA_WIDTH=8, CLK_DIV=16)
REQ-032 Reset asserted mid-operation -> tx=1, busy=0, done=0 same cycle; no done after release.
REQ-033 load 0xA5, PARITY_EN=0, shift tied to done -> tx 0,1,0,1,0,0,1,0,1,1 each 16 cycles; done every 16th cycle; busy falls with 10th shift.
REQ-034 PARITY_EN=1 load 0x07 -> 10th bit 1 (even), 0 with PARITY_ODD=1; frame 11 bits.
REQ-035 clear after 3 bits -> tx=1 next cycle, busy=0, no further done.
REQ-036 load 0x3C while busy at bit 5 -> tx=0 next cycle, timer restarts, full new frame follows.
REQ-037 load, shift, clear all high together -> load wins; shift alone while idle -> no change.
